// File: rtl/mul_pkg.sv
// Shared constants and Booth recoding helpers for the ARMv4 32x32->64 multiplier.
package mul_pkg;

  localparam int unsigned MUL_W  = 32;
  localparam int unsigned PROD_W = 64;

  // Encoding of the U input (ARM bit 22): set means two's-complement operands.
  localparam logic MUL_SIGNED = 1'b1;

  // One radix-4 Booth digit per overlapping 3-bit multiplier group.
  typedef enum logic [2:0] {
    BoothZero,
    BoothPos1,
    BoothPos2,
    BoothNeg1,
    BoothNeg2
  } booth_digit_e;

  // Group bits are {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] grp);
    booth_digit_e digit;
    unique case (grp)
      3'b000, 3'b111: digit = BoothZero;
      3'b001, 3'b010: digit = BoothPos1;
      3'b011:         digit = BoothPos2;
      3'b100:         digit = BoothNeg2;
      default:        digit = BoothNeg1;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/mul_core.sv
// Combinational 33x33 signed radix-4 Booth multiplier; the extra bit carries the
// U-controlled extension so one array serves both signed and unsigned products.
module mul_core
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  input  logic              signed_i,
  output logic [PROD_W-1:0] prod_o
);

  localparam int unsigned NumPp = (MUL_W + 2) / 2;

  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] mcand_x2;
  logic [MUL_W+2:0]  mplier;
  logic              a_ext;
  logic              b_ext;

  assign a_ext = signed_i & a_i[MUL_W-1];
  assign b_ext = signed_i & b_i[MUL_W-1];

  // Multiplicand extended to the product width; bits above 64 never reach the result.
  assign mcand    = {{(PROD_W - MUL_W){a_ext}}, a_i};
  assign mcand_x2 = {mcand[PROD_W-2:0], 1'b0};

  // 34-bit multiplier (33-bit value sign-extended to even width) with implicit b[-1] = 0.
  assign mplier = {b_ext, b_ext, b_i, 1'b0};

  always_comb begin
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] pp;
    booth_digit_e      digit;
    acc = '0;
    for (int i = 0; i < NumPp; i++) begin
      digit = booth_decode(mplier[2*i +: 3]);
      unique case (digit)
        BoothPos1: pp = mcand;
        BoothPos2: pp = mcand_x2;
        BoothNeg1: pp = ~mcand + 1'b1;
        BoothNeg2: pp = ~mcand_x2 + 1'b1;
        default:   pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    prod_o = acc;
  end

endmodule

// File: rtl/mul.sv
// ARMv4 multiplier: captures A*B into a 64-bit product register and drives either
// half back onto the shared A bus for register-file writeback.
module mul
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  inout  wire  [MUL_W-1:0] A,
  input  logic [MUL_W-1:0] B,
  input  logic             Gate_MUL,
  input  logic             MUL_HiLo,
  input  logic             LD_MUL,
  input  logic             U
);

  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] core_prod;
  logic [MUL_W-1:0]  a_out;

  mul_core u_mul_core (
    .a_i      (A),
    .b_i      (B),
    .signed_i (U == MUL_SIGNED),
    .prod_o   (core_prod)
  );

  // A load while gated would sample our own product off the bus, so it is suppressed.
  always_comb begin
    prod_d = prod_q;
    if (LD_MUL && !Gate_MUL) begin
      prod_d = core_prod;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  always_comb begin
    a_out = MUL_HiLo ? prod_q[PROD_W-1:MUL_W] : prod_q[MUL_W-1:0];
  end

  assign A = Gate_MUL ? a_out : {MUL_W{1'bz}};

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed vector table, hold/collision/reset sequences,
// and randomized loads against an arithmetic reference model.
module tb_mul;

  logic        clk;
  logic        reset;
  wire  [31:0] A;
  logic [31:0] B;
  logic        Gate_MUL;
  logic        MUL_HiLo;
  logic        LD_MUL;
  logic        U;

  logic [31:0] tb_a;
  logic        tb_en;

  int checks;
  int errors;

  assign A = tb_en ? tb_a : 32'hzzzz_zzzz;

  mul dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .Gate_MUL (Gate_MUL),
    .MUL_HiLo (MUL_HiLo),
    .LD_MUL   (LD_MUL),
    .U        (U)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic u);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    if (u) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return 64'(ua * ub);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive a one-cycle LD_MUL pulse with operands on A/B; returns at the following negedge.
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic u);
    @(negedge clk);
    tb_en    = 1'b1;
    tb_a     = a;
    B        = b;
    U        = u;
    Gate_MUL = 1'b0;
    LD_MUL   = 1'b1;
    @(negedge clk);
    LD_MUL = 1'b0;
    tb_en  = 1'b0;
  endtask

  task automatic read_both(input string name, input logic [31:0] hi, input logic [31:0] lo);
    tb_en    = 1'b0;
    Gate_MUL = 1'b1;
    MUL_HiLo = 1'b0;
    #1 check({name, " lo"}, A, lo);
    MUL_HiLo = 1'b1;
    #1 check({name, " hi"}, A, hi);
    Gate_MUL = 1'b0;
    #1;
  endtask

  // With the DUT ungated, a value the bench puts on A must come back untouched.
  task automatic check_released(input string name, input logic [31:0] pat);
    Gate_MUL = 1'b0;
    tb_en    = 1'b1;
    tb_a     = pat;
    #1 check(name, A, pat);
    tb_en = 1'b0;
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    logic [63:0] p;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ru;
    checks   = 0;
    errors   = 0;
    tb_en    = 1'b0;
    tb_a     = '0;
    B        = '0;
    U        = 1'b0;
    Gate_MUL = 1'b0;
    MUL_HiLo = 1'b0;
    LD_MUL   = 1'b0;
    reset    = 1'b1;

    vecs[0] = '{a: 32'd6,          b: 32'd7,          u: 1'b0, hi: 32'h0,        lo: 32'd42};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  u: 1'b0, hi: 32'hFFFF_FFFE, lo: 32'h1};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  u: 1'b1, hi: 32'h0,        lo: 32'h1};
    vecs[3] = '{a: 32'hFFFF_FFFE,  b: 32'd3,          u: 1'b1, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA};
    vecs[4] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  u: 1'b1, hi: 32'h4000_0000, lo: 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check_released("reset release", 32'h5A5A_A5A5);
    read_both("reset gated", 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    read_both("post-reset", 32'h0, 32'h0);

    // Directed table
    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b, vecs[i].u);
      read_both($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end
    check_released("release after load", 32'hA5A5_5A5A);

    // Hold with LD_MUL low and B changing
    load(32'd6, 32'd7, 1'b0);
    B = 32'd1000;
    repeat (2) @(negedge clk);
    read_both("hold", 32'h0, 32'd42);

    // Load request while gated is ignored
    Gate_MUL = 1'b1;
    MUL_HiLo = 1'b0;
    B        = 32'd99;
    LD_MUL   = 1'b1;
    @(negedge clk);
    LD_MUL = 1'b0;
    Gate_MUL = 1'b0;
    read_both("collision", 32'h0, 32'd42);

    // Async reset between edges discards the product and any pending load
    Gate_MUL = 1'b1;
    MUL_HiLo = 1'b0;
    @(posedge clk);
    #2 check("pre-reset lo", A, 32'd42);
    reset = 1'b1;
    #1 check("async reset lo", A, 32'h0);
    Gate_MUL = 1'b0;
    tb_en    = 1'b1;
    tb_a     = 32'd9;
    B        = 32'd9;
    LD_MUL   = 1'b1;
    @(posedge clk);
    #1 LD_MUL = 1'b0;
    tb_en = 1'b0;
    Gate_MUL = 1'b1;
    #1 check("reset pending load", A, 32'h0);
    Gate_MUL = 1'b0;
    reset = 1'b0;
    load(32'd6, 32'd7, 1'b0);
    read_both("load after reset", 32'h0, 32'd42);

    // Randomized loads against the reference model
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      ru = 1'($urandom_range(0, 1));
      if (n % 10 == 0) ra = 32'h8000_0000;
      if (n % 13 == 0) rb = 32'hFFFF_FFFF;
      p = ref_prod(ra, rb, ru);
      load(ra, rb, ru);
      read_both($sformatf("rand%0d a=%h b=%h u=%0d", n, ra, rb, ru), p[63:32], p[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
